// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes on both sides. Single-cycle ops
// finish at accept; MUL (shift-add) and DIV (restoring) iterate WIDTH times.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             flag_zero,
   output logic             flag_carry,
   output logic             flag_dz
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   typedef enum logic [2:0] {
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR, OP_ACC
   } op_t;

   state_t             state_q, state_d;
   op_t                op_q, op_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [2*WIDTH-1:0] work_q, work_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [WIDTH-1:0]   result_hi_q, result_hi_d;
   logic               zero_q, zero_d;
   logic               carry_q, carry_d;
   logic               dz_q, dz_d;

   logic [WIDTH:0]     add_sum, sub_diff, acc_sum, mul_sum, div_shift, div_sub;
   logic               div_ge;
   logic [2*WIDTH-1:0] step;
   logic               load;
   logic [WIDTH-1:0]   lo_v, hi_v;
   logic               carry_v, dz_v;

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      b_d         = b_q;
      work_d      = work_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      zero_d      = zero_q;
      carry_d     = carry_q;
      dz_d        = dz_q;
      load        = 1'b0;
      lo_v        = '0;
      hi_v        = '0;
      carry_v     = 1'b0;
      dz_v        = 1'b0;

      add_sum  = {1'b0, a} + {1'b0, b};
      sub_diff = {1'b0, a} - {1'b0, b};
      acc_sum  = {1'b0, acc_q} + {1'b0, a};

      // Upper half of work holds the partial product / remainder, lower half
      // the remaining multiplier bits / dividend-then-quotient bits.
      mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, b_q} : '0);
      div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
      div_sub   = div_shift - {1'b0, b_q};
      div_ge    = ~div_sub[WIDTH];
      if (op_q == OP_DIV)
         step = {(div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                 work_q[WIDTH-2:0], div_ge};
      else
         step = {mul_sum, work_q[WIDTH-1:1]};

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               op_d    = op_t'(op);
               b_d     = b;
               state_d = DONE;
               load    = 1'b1;
               unique case (op_t'(op))
                  OP_ADD: begin lo_v = add_sum[WIDTH-1:0];  carry_v = add_sum[WIDTH];  end
                  OP_SUB: begin lo_v = sub_diff[WIDTH-1:0]; carry_v = sub_diff[WIDTH]; end
                  OP_AND: lo_v = a & b;
                  OP_OR:  lo_v = a | b;
                  OP_XOR: lo_v = a ^ b;
                  OP_ACC: begin
                     acc_d   = acc_sum[WIDTH-1:0];
                     lo_v    = acc_sum[WIDTH-1:0];
                     carry_v = acc_sum[WIDTH];
                  end
                  OP_MUL, OP_DIV: begin
                     if (op_t'(op) == OP_DIV && b == '0) begin
                        lo_v = '1;
                        hi_v = a;
                        dz_v = 1'b1;
                     end else begin
                        load    = 1'b0;
                        state_d = BUSY;
                        work_d  = {{WIDTH{1'b0}}, a};
                        cnt_d   = CW'(WIDTH);
                     end
                  end
                  default: ;
               endcase
            end
         end
         BUSY: begin
            work_d = step;
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = DONE;
               load    = 1'b1;
               lo_v    = step[WIDTH-1:0];
               hi_v    = step[2*WIDTH-1:WIDTH];
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         result_d    = lo_v;
         result_hi_d = hi_v;
         zero_d      = (lo_v == '0) && (hi_v == '0);
         carry_d     = carry_v;
         dz_d        = dz_v;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_q        <= OP_ADD;
         b_q         <= '0;
         work_q      <= '0;
         cnt_q       <= '0;
         acc_q       <= '0;
         result_q    <= '0;
         result_hi_q <= '0;
         zero_q      <= 1'b0;
         carry_q     <= 1'b0;
         dz_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         b_q         <= b_d;
         work_q      <= work_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         zero_q      <= zero_d;
         carry_q     <= carry_d;
         dz_q        <= dz_d;
      end
   end

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = (state_q == DONE);
   assign result     = result_q;
   assign result_hi  = result_hi_q;
   assign flag_zero  = zero_q;
   assign flag_carry = carry_q;
   assign flag_dz    = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at WIDTH=8; every expected value is
// hand-computed from the arithmetic definitions.
module tb_alu_seq;

   localparam int W = 8;
   localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, MUL = 3'b010, DIV = 3'b011,
                          AND = 3'b100, OR = 3'b101, XOR = 3'b110, ACC = 3'b111;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [2:0]   op = 3'b000;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result, result_hi;
   logic         flag_zero, flag_carry, flag_dz;

   int checks = 0;
   int errors = 0;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .result_hi(result_hi), .flag_zero(flag_zero),
      .flag_carry(flag_carry), .flag_dz(flag_dz)
   );

   always #5 clk = ~clk;

   // Presents one op in IDLE; returns 1 time unit after the accept edge.
   task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      op = o; a = x; b = y; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Latency = index of the first edge (accept edge = 0) at which out_valid is 1.
   task automatic wait_done(output int lat, output logic ir_seen);
      lat = 1;
      ir_seen = in_ready;
      while (!out_valid && lat < 64) begin
         @(posedge clk); #1;
         lat++;
         if (!out_valid) ir_seen = ir_seen | in_ready;
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++; if ({result, result_hi} !== 16'h0000) begin errors++; $display("FAIL reset_result got %h exp 0000", {result, result_hi}); end
      checks++; if ({flag_zero, flag_carry, flag_dz} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {flag_zero, flag_carry, flag_dz}); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %b exp 1", in_ready); end
   endtask

   task automatic test_add();
      int lat; logic irs;
      issue(ADD, 8'hF0, 8'h20);
      wait_done(lat, irs);
      checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency got %0d exp 1", lat); end
      checks++; if (result !== 8'h10 || result_hi !== 8'h00) begin errors++; $display("FAIL add_result got %h/%h exp 10/00", result, result_hi); end
      checks++; if ({flag_zero, flag_carry, flag_dz} !== 3'b010) begin errors++; $display("FAIL add_flags got %b exp 010", {flag_zero, flag_carry, flag_dz}); end
      consume();
   endtask

   task automatic test_sub();
      int lat; logic irs;
      issue(SUB, 8'h05, 8'h07);
      wait_done(lat, irs);
      checks++; if (result !== 8'hFE) begin errors++; $display("FAIL sub_result got %h exp fe", result); end
      checks++; if ({flag_zero, flag_carry, flag_dz} !== 3'b010) begin errors++; $display("FAIL sub_flags got %b exp 010", {flag_zero, flag_carry, flag_dz}); end
      consume();
      issue(SUB, 8'h09, 8'h04);
      wait_done(lat, irs);
      checks++; if (result !== 8'h05 || flag_carry !== 1'b0) begin errors++; $display("FAIL sub_noborrow got %h c%b exp 05 c0", result, flag_carry); end
      consume();
   endtask

   task automatic test_logic();
      int lat; logic irs;
      issue(XOR, 8'hAA, 8'hAA);
      wait_done(lat, irs);
      checks++; if (result !== 8'h00 || {flag_zero, flag_carry, flag_dz} !== 3'b100) begin errors++; $display("FAIL xor_zero got %h flags %b exp 00 flags 100", result, {flag_zero, flag_carry, flag_dz}); end
      consume();
      issue(OR, 8'h50, 8'h0A);
      wait_done(lat, irs);
      checks++; if (result !== 8'h5A || flag_zero !== 1'b0) begin errors++; $display("FAIL or_result got %h z%b exp 5a z0", result, flag_zero); end
      consume();
   endtask

   task automatic test_mul();
      int lat; logic irs;
      issue(MUL, 8'd200, 8'd3);
      wait_done(lat, irs);
      checks++; if (lat !== W + 1) begin errors++; $display("FAIL mul_latency got %0d exp %0d", lat, W + 1); end
      checks++; if (irs !== 1'b0) begin errors++; $display("FAIL mul_in_ready got %b exp 0 while busy", irs); end
      checks++; if (result !== 8'h58 || result_hi !== 8'h02) begin errors++; $display("FAIL mul_result got %h/%h exp 58/02", result, result_hi); end
      checks++; if ({flag_zero, flag_carry, flag_dz} !== 3'b000) begin errors++; $display("FAIL mul_flags got %b exp 000", {flag_zero, flag_carry, flag_dz}); end
      consume();
      issue(MUL, 8'hFF, 8'hFF);
      wait_done(lat, irs);
      checks++; if (result !== 8'h01 || result_hi !== 8'hFE) begin errors++; $display("FAIL mul_max got %h/%h exp 01/fe", result, result_hi); end
      consume();
   endtask

   task automatic test_div();
      int lat; logic irs;
      issue(DIV, 8'd100, 8'd7);
      wait_done(lat, irs);
      checks++; if (lat !== W + 1) begin errors++; $display("FAIL div_latency got %0d exp %0d", lat, W + 1); end
      checks++; if (result !== 8'd14 || result_hi !== 8'd2) begin errors++; $display("FAIL div_result got %0d r%0d exp 14 r2", result, result_hi); end
      checks++; if (flag_dz !== 1'b0) begin errors++; $display("FAIL div_dz got %b exp 0", flag_dz); end
      consume();
      issue(DIV, 8'hFF, 8'h10);
      wait_done(lat, irs);
      checks++; if (result !== 8'h0F || result_hi !== 8'h0F) begin errors++; $display("FAIL div_ff got %h r%h exp 0f r0f", result, result_hi); end
      consume();
      issue(DIV, 8'h37, 8'h00);
      wait_done(lat, irs);
      checks++; if (lat !== 1) begin errors++; $display("FAIL divz_latency got %0d exp 1", lat); end
      checks++; if (result !== 8'hFF || result_hi !== 8'h37) begin errors++; $display("FAIL divz_result got %h/%h exp ff/37", result, result_hi); end
      checks++; if ({flag_zero, flag_carry, flag_dz} !== 3'b001) begin errors++; $display("FAIL divz_flags got %b exp 001", {flag_zero, flag_carry, flag_dz}); end
      consume();
   endtask

   task automatic test_backpressure();
      int lat; logic irs;
      issue(AND, 8'h3C, 8'h0F);
      wait_done(lat, irs);
      // Present a different op while held in DONE; it must not be taken.
      op = ADD; a = 8'h11; b = 8'h22; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 8'h0C || result_hi !== 8'h00) begin
            errors++;
            $display("FAIL bp_hold cycle %0d got v%b r%b %h/%h exp v1 r0 0c/00", i, out_valid, in_ready, result, result_hi);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got v%b r%b exp v0 r1", out_valid, in_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0 || result !== 8'h0C) begin errors++; $display("FAIL bp_no_accept got v%b %h exp v0 0c", out_valid, result); end
   endtask

   task automatic test_acc();
      int lat; logic irs;
      issue(ACC, 8'h80, 8'hFF);
      wait_done(lat, irs);
      checks++; if (result !== 8'h80 || flag_carry !== 1'b0) begin errors++; $display("FAIL acc1 got %h c%b exp 80 c0", result, flag_carry); end
      consume();
      issue(ADD, 8'h01, 8'h01);
      wait_done(lat, irs);
      consume();
      issue(ACC, 8'h90, 8'h00);
      wait_done(lat, irs);
      checks++; if (result !== 8'h10 || flag_carry !== 1'b1 || result_hi !== 8'h00) begin errors++; $display("FAIL acc2 got %h/%h c%b exp 10/00 c1", result, result_hi, flag_carry); end
      consume();
   endtask

   task automatic test_back_to_back();
      int n;
      logic [W-1:0] got;
      out_ready = 1'b1;
      issue(MUL, 8'd15, 8'd17);
      n = 0; got = '0;
      while (!in_ready && n < 64) begin
         @(posedge clk); #1;
         n++;
         if (out_valid) got = result;
      end
      // Next accept happens one edge after in_ready returns: period n+1 = W+2.
      checks++; if (n !== W + 1) begin errors++; $display("FAIL b2b_mul_period got %0d exp %0d", n + 1, W + 2); end
      checks++; if (got !== 8'hFF) begin errors++; $display("FAIL b2b_mul_result got %h exp ff", got); end
      issue(OR, 8'h01, 8'h02);
      n = 0;
      while (!in_ready && n < 64) begin
         @(posedge clk); #1;
         n++;
      end
      checks++; if (n !== 1) begin errors++; $display("FAIL b2b_single_period got %0d exp 2", n + 1); end
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_mul();
      int lat; logic irs; logic seen;
      issue(MUL, 8'd9, 8'd9);
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_state got r%b v%b exp r1 v0", in_ready, out_valid); end
      checks++; if ({result, result_hi, flag_zero, flag_carry, flag_dz} !== 19'h0) begin errors++; $display("FAIL rst_mid_regs got %h/%h flags %b exp 0", result, result_hi, {flag_zero, flag_carry, flag_dz}); end
      seen = 1'b0;
      repeat (2) begin @(posedge clk); #1; seen = seen | out_valid; end
      rst_n = 1'b1;
      repeat (W + 2) begin @(posedge clk); #1; seen = seen | out_valid; end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_no_pulse got %b exp 0", seen); end
      issue(ADD, 8'd1, 8'd1);
      wait_done(lat, irs);
      checks++; if (lat !== 1 || result !== 8'd2) begin errors++; $display("FAIL rst_add got lat %0d res %0d exp lat 1 res 2", lat, result); end
      consume();
      issue(ACC, 8'h05, 8'h00);
      wait_done(lat, irs);
      checks++; if (result !== 8'h05 || flag_carry !== 1'b0) begin errors++; $display("FAIL rst_acc_cleared got %h c%b exp 05 c0", result, flag_carry); end
      consume();
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_logic();
      test_mul();
      test_div();
      test_backpressure();
      test_acc();
      test_back_to_back();
      test_reset_mid_mul();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU with valid/ready handshakes on both sides. Operands are WIDTH bits. Single-cycle logic and add/subtract ops sit beside an iterative shift-add multiplier and a restoring divider, and an accumulator register supports running sums. The block sits between the pin-level input capture and the output mux, and replaces the fixed 4-bit single-cycle ALU in the TinyTapeout top.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous and active-low.
- in_valid  input  1  operand/op presented.
- in_ready  output  1  block can accept; high only in IDLE.
- op  input  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 ACC.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- out_valid  output  1  result registers hold a completed result.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  low word (sum, difference, product low, quotient, logic result, accumulator).
- result_hi  output  WIDTH  high word (product high, remainder); 0 for all other ops.
- flag_zero  output  1  result==0 and result_hi==0.
- flag_carry  output  1  carry out (ADD, ACC), borrow (SUB); 0 otherwise.
- flag_dz  output  1  DIV with b==0.

## Operation
- States: IDLE, BUSY, DONE.
- Accept: in_valid && in_ready at a rising edge latches op, a and b.
- Accepting MUL, or DIV with b!=0, moves to BUSY with iteration counter = WIDTH. The counter is clog2(WIDTH)+1 bits.
- All other ops, and DIV with b==0, compute at accept and move to DONE.
- BUSY performs one iteration per cycle and decrements the counter.
  - MUL: LSB-first shift-add into a 2·WIDTH product register.
  - DIV: restoring shift-subtract. Quotient bits enter from the LSB; remainder stays in the range 0..b-1.
- BUSY moves to DONE on the cycle the last iteration completes. result, result_hi and the flags are loaded on that same edge.
- DONE holds all outputs stable until out_ready is high at an edge, then moves to IDLE. in_ready=0 during BUSY and DONE; there is no accept in the DONE→IDLE cycle.
- Arithmetic is modulo 2^WIDTH:
  - ADD: carry = bit WIDTH of a+b.
  - SUB: carry = (a<b).
  - MUL: {result_hi,result} = a·b exact.
  - DIV b==0: result = all ones, result_hi = a, flag_dz = 1.
- ACC: acc ← acc + a, with b ignored. result = new acc, carry = carry out. acc resets to 0 and persists between ops; no other op touches it.
- flag_dz is 0 for every op except DIV by zero.

## Timing
- Reset (asynchronous, any state, including mid-BUSY): state→IDLE. The in-flight op is discarded with no out_valid pulse.
  - Reset values: acc=0, result=0, result_hi=0, all flags 0, out_valid=0.
  - in_ready=1 while rst_n is low and after release.
- Latency, measured from the accept edge to the first edge at which out_valid=1:
  - single-cycle ops, and DIV by zero: 1 cycle;
  - MUL, and DIV with b!=0: WIDTH+1 cycles.
- Throughput: with out_ready held high, one single-cycle op per 2 cycles and one MUL/DIV per WIDTH+2 cycles.
- out_valid is registered: high exactly in DONE.
- in_ready is decoded from state: high exactly in IDLE.
- Inputs are sampled only on the accept edge. Changes to a, b or op during BUSY or DONE have no effect.

## Test plan
- Reset: rst_n low mid-stream → in_ready=1, out_valid=0, result=0, result_hi=0, all flags 0.
- Single-cycle ops, WIDTH=8:
  - ADD 0xF0+0x20 → result 0x10, carry=1, out_valid one cycle after accept.
  - SUB 0x05−0x07 → result 0xFE, carry=1.
  - XOR 0xAA^0xAA → result 0x00, zero=1.
- MUL 200×3 → result 0x58, result_hi 0x02; out_valid 9 cycles after accept; in_ready=0 throughout.
- DIV:
  - 100÷7 → result 14, result_hi 2, dz=0, latency 9 cycles.
  - 0x37÷0 → result 0xFF, result_hi 0x37, dz=1, latency 1 cycle.
- Backpressure and ACC:
  - Hold out_ready=0 for 5 cycles after DONE → outputs stable, in_ready=0, in_valid ignored; completes on out_ready=1.
  - ACC 0x80 then ACC 0x90 → results 0x80 (carry 0), then 0x10 (carry 1).
- Reset mid-MUL: assert rst_n low at BUSY iteration 4 → no out_valid pulse, acc=0. A following ADD 1+1 gives 2 with normal latency.
